meter_ctrl: RTL and testbench
=============================

METER_CTRL -- requirements
Module: meter_ctrl

Interface
REQ-001 SHALL have parameter: MAX_BCD, 16'h9999, saturation ceiling of the 4-digit BCD count.
REQ-002 SHALL have parameter: LOW_BCD, 16'h0200, count below which the LOW (fast-blink) state applies.
REQ-003 SHALL have port: fastclk  input  1  100 MHz system clock; the block's only clock.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: sec_tick  input  1  one-fastclk-cycle strobe, once per second.
REQ-006 SHALL have port: half_tick  input  1  one-fastclk-cycle strobe, once per 0.5 s; coincides with every sec_tick.
REQ-007 SHALL have port: add_req  input  4  debounced single-cycle pulses. [3]=+50, [2]=+150, [1]=+200, [0]=+500 (BCD seconds).
REQ-008 SHALL have port: set15  input  1  level; forces count to 0015.
REQ-009 SHALL have port: set185  input  1  level; forces count to 0185.
REQ-010 SHALL have port: count  output  16  current time, 4 packed BCD digits, [15:12] = thousands.
REQ-011 SHALL have port: blank  output  1  1 = display-enable deasserted (blink off phase).
REQ-012 SHALL have port: mode  output  2  current FSM state encoding.

Function
REQ-013 SHALL latch each add_req bit into a pending bit at the clock edge where it is high; a new pulse on an already-pending bit is absorbed with no double add.
REQ-014 SHALL serve at most one pending add per cycle, in fixed priority [3] > [2] > [1] > [0], clearing that pending bit in the serving cycle.
REQ-015 SHALL compute add results in BCD: count + increment, saturating at MAX_BCD, never wrapping.
REQ-016 SHALL let set15 override everything else while high; set185 SHALL override everything except set15. While either is high, pending adds are cleared and decrements are suppressed.
REQ-017 SHALL, on sec_tick with count != 0, decrement count by 1 in BCD, borrowing across digits (e.g. 1000 -> 0999). When count == 0, sec_tick SHALL have no effect.
REQ-018 SHALL, when sec_tick and an add serve fall in the same cycle, apply the add and set a dec_pending flag; the decrement SHALL be applied on the next cycle that has no add serve. Only one deferred decrement is held.
REQ-019 SHALL update count exactly one cycle after the qualifying event (registered output).
REQ-020 SHALL implement FSM states EXPIRED (count == 0), LOW (0 < count < LOW_BCD), NORMAL (count >= LOW_BCD), re-evaluated from the next count every cycle.
REQ-021 SHALL hold blank = 0 in NORMAL.
REQ-022 SHALL toggle blank on each half_tick in LOW.
REQ-023 SHALL toggle blank on each sec_tick in EXPIRED.
REQ-024 SHALL force blank = 0 in the same cycle mode changes on any state transition, so each blink phase starts visible.
REQ-025 SHALL encode mode as EXPIRED = 2'b00, LOW = 2'b01, NORMAL = 2'b10; 2'b11 is unreachable.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force: count = 0000, mode = EXPIRED, blank = 0, pending adds = 0, dec_pending = 0.
REQ-027 SHALL drop all in-flight pending requests on reset mid-operation; no request issued before rst_n rises is honoured afterwards.
REQ-028 SHALL ignore requests on the first clock edge after rst_n deasserts only if that edge falls within the reset recovery window; otherwise requests are captured normally.

Structure
REQ-029 SHALL place in shared package meter_pkg: the increment constants (0050, 0150, 0200, 0500), preset constants (0015, 0185), MAX_BCD/LOW_BCD defaults, and the mode state encoding.
REQ-030 SHALL instantiate one sub-module, bcd_addsub_sat: 16-bit BCD add/subtract-by-1 with saturation at MAX_BCD and floor at 0000.
REQ-031 SHALL keep the arbiter, FSM and blink logic in meter_ctrl.

Verification
REQ-032 SHALL cover: reset, then add_req = 4'b0001 -> count = 0500 one cycle later, mode = NORMAL, blank = 0.
REQ-033 SHALL cover: count = 0100, add_req = 4'b1111 in one cycle -> count 0150, 0300, 0500, 1000 on four successive cycles.
REQ-034 SHALL cover: count = 9800, add +500 -> count 9999 (saturated); next sec_tick -> 9998.
REQ-035 SHALL cover: count = 0200, sec_tick -> count 0199, mode = LOW, blank = 0, then blank toggles on each half_tick.
REQ-036 SHALL cover: count = 0001 with sec_tick and add +50 in the same cycle -> count 0051, then 0050 the next cycle. Also: count = 0000 with sec_tick -> count stays 0000 and blank toggles.
REQ-037 SHALL cover: set15 high with pending adds and sec_tick -> count = 0015 and pending cleared. Also: rst_n low mid-serve -> count = 0000 immediately, with no stale add after release.

Source files
------------

// File: rtl/meter_pkg.sv
`default_nettype none
// ============================================================================
// Module : meter_pkg
// Brief  : Shared constants for the parking-meter controller: BCD increments,
//          presets, default thresholds and the mode state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package meter_pkg;

    localparam logic [15:0] c_inc_50     = 16'h0050;
    localparam logic [15:0] c_inc_150    = 16'h0150;
    localparam logic [15:0] c_inc_200    = 16'h0200;
    localparam logic [15:0] c_inc_500    = 16'h0500;

    localparam logic [15:0] c_preset_15  = 16'h0015;
    localparam logic [15:0] c_preset_185 = 16'h0185;

    localparam logic [15:0] c_max_bcd_dflt = 16'h9999;
    localparam logic [15:0] c_low_bcd_dflt = 16'h0200;

    localparam int unsigned c_mode_w = 2;
    localparam logic [c_mode_w-1:0] c_mode_expired = 2'b00;
    localparam logic [c_mode_w-1:0] c_mode_low     = 2'b01;
    localparam logic [c_mode_w-1:0] c_mode_normal  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/meter_if.sv
`default_nettype none
// ============================================================================
// Module : meter_if
// Brief  : Tick/request inputs and display outputs of the meter controller.
// Rev    : 1.0  initial release
// ============================================================================
interface meter_if;
    import meter_pkg::*;

    logic                sec_tick;
    logic                half_tick;
    logic [3:0]          add_req;
    logic                set15;
    logic                set185;
    logic [15:0]         count;
    logic                blank;
    logic [c_mode_w-1:0] mode;

    modport master (
        output sec_tick, half_tick, add_req, set15, set185,
        input  count, blank, mode
    );

    modport slave (
        input  sec_tick, half_tick, add_req, set15, set185,
        output count, blank, mode
    );
endinterface
`default_nettype wire

// File: rtl/bcd_addsub_sat.sv
`default_nettype none
// ============================================================================
// Module : bcd_addsub_sat
// Brief  : 4-digit packed BCD add (saturating at MAX_BCD) or decrement by one
//          (floored at 0000). Purely combinational.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_addsub_sat
    import meter_pkg::*;
#(
    parameter logic [15:0] MAX_BCD = c_max_bcd_dflt
) (
    input  logic [15:0] a,
    input  logic [15:0] inc,
    input  logic        sub1,
    output logic [15:0] y
);

    logic [4:0]  w_dsum;
    logic        w_carry;
    logic [15:0] w_sum;
    logic        w_borrow;
    logic [15:0] w_diff;

    // Digit-serial add with decimal adjust; carry out of the top digit means overflow.
    always_comb begin
        w_carry = 1'b0;
        w_sum   = '0;
        w_dsum  = '0;
        for (int i = 0; i < 4; i++) begin
            w_dsum = {1'b0, a[i*4 +: 4]} + {1'b0, inc[i*4 +: 4]} + {4'b0000, w_carry};
            if (w_dsum > 5'd9) begin
                w_dsum  = w_dsum + 5'd6;
                w_carry = 1'b1;
            end else begin
                w_carry = 1'b0;
            end
            w_sum[i*4 +: 4] = w_dsum[3:0];
        end
    end

    always_comb begin
        w_borrow = 1'b1;
        w_diff   = a;
        for (int i = 0; i < 4; i++) begin
            if (w_borrow) begin
                if (a[i*4 +: 4] == 4'd0) begin
                    w_diff[i*4 +: 4] = 4'd9;
                end else begin
                    w_diff[i*4 +: 4] = a[i*4 +: 4] - 4'd1;
                    w_borrow         = 1'b0;
                end
            end
        end
    end

    // Packed BCD orders the same as binary, so plain magnitude compares are valid.
    always_comb begin
        if (sub1) begin
            y = (a == 16'h0000) ? 16'h0000 : w_diff;
        end else if (w_carry || (w_sum > MAX_BCD)) begin
            y = MAX_BCD;
        end else begin
            y = w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/meter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : meter_ctrl
// Brief  : Parking-meter time keeper: pending-add arbiter, BCD countdown,
//          EXPIRED/LOW/NORMAL state machine and display blink control.
// Rev    : 1.0  initial release
// ============================================================================
module meter_ctrl
    import meter_pkg::*;
#(
    parameter logic [15:0] MAX_BCD = c_max_bcd_dflt,
    parameter logic [15:0] LOW_BCD = c_low_bcd_dflt
) (
    input  logic     fastclk,
    input  logic     rst_n,
    meter_if.slave   bus
);

    logic [15:0]         r_count;
    logic [3:0]          r_pend;
    logic                r_dec_pend;
    logic [c_mode_w-1:0] r_mode;
    logic                r_blank;

    logic                w_set;
    logic [3:0]          w_req;
    logic [3:0]          w_serve;
    logic [15:0]         w_inc;
    logic                w_any_serve;
    logic                w_dec_req;
    logic [15:0]         w_arith;
    logic [15:0]         w_count_next;
    logic [3:0]          w_pend_next;
    logic                w_dec_pend_next;
    logic [c_mode_w-1:0] w_mode_next;
    logic                w_blank_next;

    assign w_set     = bus.set15 | bus.set185;
    assign w_req     = r_pend | bus.add_req;
    assign w_dec_req = bus.sec_tick | r_dec_pend;

    // Fixed-priority arbiter: +50 > +150 > +200 > +500, one serve per cycle.
    always_comb begin
        w_serve = 4'b0000;
        w_inc   = 16'h0000;
        if (!w_set) begin
            if (w_req[3]) begin
                w_serve = 4'b1000;
                w_inc   = c_inc_50;
            end else if (w_req[2]) begin
                w_serve = 4'b0100;
                w_inc   = c_inc_150;
            end else if (w_req[1]) begin
                w_serve = 4'b0010;
                w_inc   = c_inc_200;
            end else if (w_req[0]) begin
                w_serve = 4'b0001;
                w_inc   = c_inc_500;
            end
        end
    end

    assign w_any_serve = |w_serve;

    bcd_addsub_sat #(
        .MAX_BCD (MAX_BCD)
    ) u_addsub (
        .a    (r_count),
        .inc  (w_inc),
        .sub1 (!w_any_serve),
        .y    (w_arith)
    );

    // A tick that collides with an add is parked in r_dec_pend; a tick arriving
    // while one is already parked consumes the parked one and stays parked.
    always_comb begin
        w_count_next    = r_count;
        w_pend_next     = w_req & ~w_serve;
        w_dec_pend_next = r_dec_pend;
        if (bus.set15) begin
            w_count_next    = c_preset_15;
            w_pend_next     = 4'b0000;
            w_dec_pend_next = 1'b0;
        end else if (bus.set185) begin
            w_count_next    = c_preset_185;
            w_pend_next     = 4'b0000;
            w_dec_pend_next = 1'b0;
        end else if (w_any_serve) begin
            w_count_next    = w_arith;
            w_dec_pend_next = w_dec_req;
        end else if (w_dec_req) begin
            w_count_next    = w_arith;
            w_dec_pend_next = bus.sec_tick & r_dec_pend;
        end
    end

    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 16'h0000;
            r_pend     <= 4'b0000;
            r_dec_pend <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_pend     <= w_pend_next;
            r_dec_pend <= w_dec_pend_next;
        end
    end

    // FSM state register
    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= c_mode_expired;
            r_blank <= 1'b0;
        end else begin
            r_mode  <= w_mode_next;
            r_blank <= w_blank_next;
        end
    end

    // FSM next state, classified from the count being loaded this cycle
    always_comb begin
        w_mode_next = c_mode_normal;
        if (w_count_next == 16'h0000) begin
            w_mode_next = c_mode_expired;
        end else if (w_count_next < LOW_BCD) begin
            w_mode_next = c_mode_low;
        end
    end

    // FSM output: any transition restarts the blink in the visible phase
    always_comb begin
        w_blank_next = 1'b0;
        if (w_mode_next == r_mode) begin
            case (r_mode)
                c_mode_low:     w_blank_next = r_blank ^ bus.half_tick;
                c_mode_expired: w_blank_next = r_blank ^ bus.sec_tick;
                default:        w_blank_next = 1'b0;
            endcase
        end
    end

    assign bus.count = r_count;
    assign bus.mode  = r_mode;
    assign bus.blank = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_meter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_meter_ctrl
// Brief  : Directed scenarios plus random traffic against an integer-valued
//          reference model of the meter controller.
// Rev    : 1.0  initial release
// ============================================================================
module tb_meter_ctrl;

    logic fastclk = 1'b0;
    logic rst_n   = 1'b0;

    meter_if bus ();

    meter_ctrl #(
        .MAX_BCD (16'h9999),
        .LOW_BCD (16'h0200)
    ) dut (
        .fastclk (fastclk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 fastclk = ~fastclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: plain decimal seconds
    int       m_count;
    bit [3:0] m_pend;
    bit       m_dec;
    int       m_mode;
    bit       m_blank;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int mode_of(input int v);
        if (v == 0)   return 0;
        if (v < 200)  return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_pend  = '0;
        m_dec   = 1'b0;
        m_mode  = 0;
        m_blank = 1'b0;
    endtask

    task automatic model_step(input bit sec, input bit half, input bit [3:0] add,
                              input bit s15, input bit s185);
        int       incs [4];
        bit [3:0] req;
        int       served;
        int       nm;
        incs   = '{500, 200, 150, 50};
        req    = m_pend | add;
        served = -1;
        if (s15 || s185) begin
            m_count = s15 ? 15 : 185;
            m_pend  = '0;
            m_dec   = 1'b0;
        end else begin
            for (int i = 3; i >= 0; i--)
                if (req[i] && served < 0) served = i;
            if (served >= 0) begin
                req[served] = 1'b0;
                m_count = (m_count + incs[served] > 9999) ? 9999 : m_count + incs[served];
                if (sec) m_dec = 1'b1;
            end else if (sec || m_dec) begin
                if (m_count > 0) m_count--;
                m_dec = sec && m_dec;
            end
            m_pend = req;
        end
        nm = mode_of(m_count);
        if (nm != m_mode)  m_blank = 1'b0;
        else if (nm == 2)  m_blank = 1'b0;
        else if (nm == 1)  m_blank = m_blank ^ half;
        else               m_blank = m_blank ^ sec;
        m_mode = nm;
    endtask

    task automatic clear_inputs();
        bus.sec_tick  = 1'b0;
        bus.half_tick = 1'b0;
        bus.add_req   = 4'b0000;
        bus.set15     = 1'b0;
        bus.set185    = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, bus.count, to_bcd(m_count));
        check({tag, "_mode"},  16'(bus.mode), 16'(m_mode));
        check({tag, "_blank"}, 16'(bus.blank), 16'(m_blank));
    endtask

    task automatic step(input bit sec, input bit half, input bit [3:0] add,
                        input bit s15, input bit s185, input string tag);
        bit h;
        h = half | sec;
        @(negedge fastclk);
        bus.sec_tick  = sec;
        bus.half_tick = h;
        bus.add_req   = add;
        bus.set15     = s15;
        bus.set185    = s185;
        @(posedge fastclk);
        model_step(sec, h, add, s15, s185);
        #1;
        check_model(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "idle");
    endtask

    task automatic do_reset();
        @(negedge fastclk);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        @(negedge fastclk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        model_reset();
        #1;
        check_model("por");
        repeat (2) @(negedge fastclk);
        rst_n = 1'b1;

        // First add after reset
        step(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, "add500");
        check("add500_const", bus.count, 16'h0500);
        check("add500_mode", 16'(bus.mode), 16'd2);

        // 0100 then all four requests in one cycle
        do_reset();
        step(1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, "to50");
        step(1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, "to100");
        check("pre_burst", bus.count, 16'h0100);
        step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, "burst0");
        check("burst_0150", bus.count, 16'h0150);
        idle(1);
        check("burst_0300", bus.count, 16'h0300);
        idle(1);
        check("burst_0500", bus.count, 16'h0500);
        idle(1);
        check("burst_1000", bus.count, 16'h1000);

        // Climb to 9800, saturate, then count down
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, "climb");
        for (int i = 0; i < 2; i++)  step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, "climb");
        check("at_9800", bus.count, 16'h9800);
        step(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, "sat");
        check("sat_9999", bus.count, 16'h9999);
        step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, "sat_dec");
        check("dec_9998", bus.count, 16'h9998);

        // NORMAL -> LOW on a tick, then half-tick blinking
        do_reset();
        step(1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, "to200");
        step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, "to199");
        check("low_0199", bus.count, 16'h0199);
        check("low_mode", 16'(bus.mode), 16'd1);
        check("low_blank0", 16'(bus.blank), 16'd0);
        step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, "half1");
        check("low_blank1", 16'(bus.blank), 16'd1);
        step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, "half2");
        check("low_blank2", 16'(bus.blank), 16'd0);

        // Tick colliding with an add at 0001, then expiry
        step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "set15");
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, "down");
        check("at_0001", bus.count, 16'h0001);
        step(1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, "collide");
        check("collide_0051", bus.count, 16'h0051);
        idle(1);
        check("deferred_0050", bus.count, 16'h0050);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, "drain");
        check("expired_0000", bus.count, 16'h0000);
        step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, "exp_tick");
        check("exp_stays0", bus.count, 16'h0000);
        check("exp_blank1", 16'(bus.blank), 16'd1);

        // set15 discards pending adds and suppresses the tick
        step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, "pend");
        step(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, "set15_ov");
        check("set15_0015", bus.count, 16'h0015);
        idle(3);
        check("set15_nopend", bus.count, 16'h0015);

        // Asynchronous reset while requests are in flight
        step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, "inflight");
        clear_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_count", bus.count, 16'h0000);
        check("arst_mode", 16'(bus.mode), 16'd0);
        @(negedge fastclk);
        rst_n = 1'b1;
        idle(4);
        check("no_stale", bus.count, 16'h0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit       sec, half, s15, s185;
            bit [3:0] add;
            sec  = ($urandom_range(0, 19) == 0);
            half = ($urandom_range(0, 9) == 0);
            s15  = ($urandom_range(0, 149) == 0);
            s185 = ($urandom_range(0, 99) == 0);
            for (int b = 0; b < 4; b++) add[b] = ($urandom_range(0, 9) == 0);
            step(sec, half, add, s15, s185, "rand");
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
